// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave control FSM.
package spi_pkg;

  localparam int ADDR_BITS_DEF = 8;
  localparam int DATA_BITS_DEF = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DECODE,
    ST_READ_LOAD,
    ST_READ_OUT,
    ST_WRITE_IN,
    ST_WRITE_MEM,
    ST_DONE
  } state_e;

  // Wide enough to hold the larger phase length exactly, with one spare bit.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for the command and data phases: clear, increment, terminal compare.
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] target_i,
  output logic         term_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High while the count sits on the index of the phase's final bit.
  assign term_o = (count_q == target_i);

endmodule

// File: rtl/spi_fsm.sv
// SPI slave control FSM: sequences command shift, address latch, memory read/write
// and MISO enable from conditioned chip-select and SCLK edge pulses.
module spi_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cs_cond,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic sr_shift,
  output logic sr_load,
  output logic addr_we,
  output logic dm_we,
  output logic miso_en
);

  localparam int CNT_W = cnt_width(ADDR_BITS, DATA_BITS);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_e           state_q;
  state_e           state_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_target;
  logic             cnt_term;

  spi_bit_counter #(
    .W(CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .target_i (cnt_target),
    .term_o   (cnt_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_shift   = 1'b0;
    sr_load    = 1'b0;
    addr_we    = 1'b0;
    dm_we      = 1'b0;
    miso_en    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_target = ADDR_LAST;

    // Chip-select deassertion outside IDLE wins over everything else.
    if (cs_cond && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          if (!cs_cond) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          cnt_target = ADDR_LAST;
          if (sclk_pos) begin
            sr_shift = 1'b1;
            cnt_inc  = 1'b1;
            if (cnt_term) begin
              state_d = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          addr_we = 1'b1;
          cnt_clr = 1'b1;
          state_d = (rw_bit == RW_READ) ? ST_READ_LOAD : ST_WRITE_IN;
        end
        ST_READ_LOAD: begin
          sr_load = 1'b1;
          state_d = ST_READ_OUT;
        end
        ST_READ_OUT: begin
          miso_en    = 1'b1;
          cnt_target = DATA_LAST;
          if (sclk_neg) begin
            sr_shift = 1'b1;
            cnt_inc  = 1'b1;
            if (cnt_term) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_WRITE_IN: begin
          cnt_target = DATA_LAST;
          if (sclk_pos) begin
            sr_shift = 1'b1;
            cnt_inc  = 1'b1;
            if (cnt_term) begin
              state_d = ST_WRITE_MEM;
            end
          end
        end
        ST_WRITE_MEM: begin
          dm_we   = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed-plus-random bench for spi_fsm; expected outputs come from a
// transaction-level timeline built from the protocol rules.
module tb_spi_fsm;

  logic clk;
  logic reset_n;
  logic cs_cond;
  logic sclk_pos;
  logic sclk_neg;
  logic rw_bit;
  logic sr_shift;
  logic sr_load;
  logic addr_we;
  logic dm_we;
  logic miso_en;

  int compared   = 0;
  int mismatched = 0;

  // Output vector order: {sr_shift, sr_load, addr_we, dm_we, miso_en}
  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_SHIFT = 5'b10000;
  localparam logic [4:0] E_LOAD  = 5'b01000;
  localparam logic [4:0] E_ADDR  = 5'b00100;
  localparam logic [4:0] E_DMWE  = 5'b00010;
  localparam logic [4:0] E_MISO  = 5'b00001;
  localparam logic [4:0] E_RDSH  = 5'b10001;

  localparam int NBITS = 8;

  spi_fsm dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs_cond  (cs_cond),
    .sclk_pos (sclk_pos),
    .sclk_neg (sclk_neg),
    .rw_bit   (rw_bit),
    .sr_shift (sr_shift),
    .sr_load  (sr_load),
    .addr_we  (addr_we),
    .dm_we    (dm_we),
    .miso_en  (miso_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {sr_shift, sr_load, addr_we, dm_we, miso_en};
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drive one clk cycle of inputs and check the outputs mid-cycle.
  task automatic cyc(input logic cs, input logic p, input logic n,
                     input logic [4:0] expv, input string tag);
    cs_cond  = cs;
    sclk_pos = p;
    sclk_neg = n;
    @(negedge clk);
    chk(tag, expv);
    @(posedge clk);
    #1;
  endtask

  // Idle gaps between SCLK edges, carrying only pulses that must be ignored.
  task automatic gaps(input bit neg_phase, input logic [4:0] expv, input string tag);
    int n;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      if (neg_phase) cyc(1'b0, rb(), 1'b0, expv, tag);
      else           cyc(1'b0, 1'b0, rb(), expv, tag);
    end
  endtask

  // ab_phase: 0 none, 1 during command, 2 during data; abort lands on pulse ab_idx.
  // rst_idx >= 0 asserts reset_n during READ_OUT before data pulse rst_idx.
  task automatic txn(input logic [7:0] cmd, input int ab_phase, input int ab_idx,
                     input int rst_idx);
    logic rw;
    rw = cmd[0];
    cyc(1'b0, 1'b1, rb(), E_NONE, "idle_start");
    for (int i = 0; i < NBITS; i++) begin
      gaps(1'b0, E_NONE, "addr_gap");
      if (ab_phase == 1 && ab_idx == i) begin
        cyc(1'b1, 1'b1, rb(), E_NONE, "abort_cmd");
        cyc(1'b1, rb(), rb(), E_NONE, "post_abort");
        return;
      end
      cyc(1'b0, 1'b1, rb(), E_SHIFT, "addr_shift");
    end
    rw_bit = rw;
    cyc(1'b0, rb(), rb(), E_ADDR, "decode");
    rw_bit = rb();
    if (rw) begin
      cyc(1'b0, rb(), rb(), E_LOAD, "read_load");
      for (int j = 0; j < NBITS; j++) begin
        gaps(1'b1, E_MISO, "rd_gap");
        if (rst_idx == j) begin
          cs_cond = 1'b0; sclk_pos = 1'b0; sclk_neg = 1'b0;
          #2;
          chk("pre_reset", E_MISO);
          reset_n = 1'b0;
          #1;
          chk("async_reset", E_NONE);
          @(negedge clk);
          chk("in_reset", E_NONE);
          @(posedge clk);
          #1;
          cyc(1'b0, rb(), rb(), E_NONE, "in_reset_cyc");
          cyc(1'b1, rb(), rb(), E_NONE, "in_reset_cyc");
          return;
        end
        if (ab_phase == 2 && ab_idx == j) begin
          cyc(1'b1, rb(), 1'b1, E_NONE, "abort_rd");
          cyc(1'b1, rb(), rb(), E_NONE, "post_abort");
          return;
        end
        cyc(1'b0, rb(), 1'b1, E_RDSH, "rd_shift");
      end
    end else begin
      for (int j = 0; j < NBITS; j++) begin
        gaps(1'b0, E_NONE, "wr_gap");
        if (ab_phase == 2 && ab_idx == j) begin
          cyc(1'b1, 1'b1, rb(), E_NONE, "abort_wr");
          cyc(1'b1, rb(), rb(), E_NONE, "post_abort");
          return;
        end
        cyc(1'b0, 1'b1, rb(), E_SHIFT, "wr_shift");
      end
      cyc(1'b0, rb(), rb(), E_DMWE, "write_mem");
    end
    for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
      cyc(1'b0, rb(), rb(), E_NONE, "done");
    end
    cyc(1'b1, rb(), rb(), E_NONE, "cs_high");
    cyc(1'b1, rb(), rb(), E_NONE, "idle_cs_high");
  endtask

  initial begin
    logic [7:0] cmd;
    int ph;
    reset_n = 1'b0;
    cs_cond = 1'b1;
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;
    rw_bit = 1'b0;
    #1;
    chk("reset_state", E_NONE);
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 1'b1, E_NONE, "reset_hold");
    cyc(1'b1, 1'b1, 1'b0, E_NONE, "reset_hold");
    reset_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, E_NONE, "idle_cs_high");

    txn(8'h54, 0, 0, -1);
    txn(8'h55, 0, 0, -1);
    txn(8'h54, 1, 4, -1);
    txn(8'h54, 0, 0, -1);
    txn(8'h54, 2, 7, -1);
    txn(8'h55, 2, 7, -1);
    txn(8'h55, 0, 0, 3);
    reset_n = 1'b1;
    cyc(1'b1, rb(), rb(), E_NONE, "post_reset_idle");
    txn(8'h55, 0, 0, 5);
    reset_n = 1'b1;
    txn(8'h55, 0, 0, -1);

    for (int t = 0; t < 24; t++) begin
      cmd = 8'($urandom);
      ph  = int'($urandom_range(0, 4));
      if (ph > 2) ph = 0;
      txn(cmd, ph, int'($urandom_range(0, NBITS - 1)), -1);
    end
    cyc(1'b0, 1'b1, 1'b0, E_NONE, "idle_start");
    cyc(1'b0, 1'b1, 1'b0, E_SHIFT, "addr_shift");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
